// File: rtl/math_pkg.sv
// rtl/math_pkg.sv - shared constants and arbiter state encoding for the 96-bit adder block
package math_pkg;

    localparam int MATH_ADD_96_LAT = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

endpackage

// File: rtl/math_add_96_arb_rr_arb.sv
// rtl/math_add_96_arb_rr_arb.sv - rotating-priority one-hot grant starting at ptr
module rr_arb #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant
);

    logic [W:0]   pos;
    logic [W-1:0] sel;
    logic         found;

    // Scan from ptr upward, wrapping at N rather than at 2**W.
    always_comb begin
        grant = '0;
        found = 1'b0;
        pos   = '0;
        sel   = '0;
        for (int i = 0; i < N; i++) begin
            pos = {1'b0, ptr} + (W+1)'(i);
            if (pos >= (W+1)'(N)) begin
                pos = pos - (W+1)'(N);
            end
            sel = pos[W-1:0];
            if (!found && req[sel]) begin
                grant[sel] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/math_add_96_arb.sv
// rtl/math_add_96_arb.sv - round-robin sharing of one pipelined 96-bit adder; MATH_ADD_96_ARB_PRIO_EN gives requester 0 strict priority
module math_add_96_arb
    import math_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int ADD_LAT = MATH_ADD_96_LAT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*96-1:0] req_dina,
    input  logic [NUM_REQ*96-1:0] req_dinb,
    output logic [95:0]           add_dina,
    output logic [95:0]           add_dinb,
    input  logic [96:0]           add_dout,
    output logic                  res_valid,
    output logic [ID_W-1:0]       res_id,
    output logic [96:0]           res_data,
    input  logic                  drain,
    output logic                  idle
);

    logic [NUM_REQ-1:0] rr_req;
    logic [NUM_REQ-1:0] rr_grant;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    g_idx;
    logic [95:0]        dina_sel;
    logic [95:0]        dinb_sel;
    logic               xfer;
    logic               drains_out;
    logic [ADD_LAT:0]   tv;
    logic [ID_W-1:0]    tid [ADD_LAT+1];
    arb_state_t         state;
    arb_state_t         state_n;

`ifdef MATH_ADD_96_ARB_PRIO_EN
    assign rr_req = req_valid & ~NUM_REQ'(1);
    assign grant  = req_valid[0] ? NUM_REQ'(1) : rr_grant;
`else
    assign rr_req = req_valid;
    assign grant  = rr_grant;
`endif

    rr_arb #(
        .N (NUM_REQ),
        .W (ID_W)
    ) u_rr_arb (
        .req   (rr_req),
        .ptr   (rr_ptr),
        .grant (rr_grant)
    );

    assign req_ready = (rst || drain) ? '0 : grant;
    assign xfer      = |(req_valid & req_ready);

    always_comb begin
        g_idx    = '0;
        dina_sel = '0;
        dinb_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                g_idx    = ID_W'(i);
                dina_sel = req_dina[96*i +: 96];
                dinb_sel = req_dinb[96*i +: 96];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            add_dina <= '0;
            add_dinb <= '0;
            rr_ptr   <= '0;
        end else if (xfer) begin
            add_dina <= dina_sel;
            add_dinb <= dinb_sel;
`ifdef MATH_ADD_96_ARB_PRIO_EN
            if (!req_ready[0]) begin
                rr_ptr <= (int'(g_idx) == NUM_REQ-1) ? '0 : g_idx + 1'b1;
            end
`else
            rr_ptr <= (int'(g_idx) == NUM_REQ-1) ? '0 : g_idx + 1'b1;
`endif
        end
    end

    // Shadow of the adder pipeline: one extra stage covers the operand register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tv <= '0;
            for (int k = 0; k <= ADD_LAT; k++) begin
                tid[k] <= '0;
            end
        end else begin
            tv     <= {tv[ADD_LAT-1:0], xfer};
            tid[0] <= g_idx;
            for (int k = 1; k <= ADD_LAT; k++) begin
                tid[k] <= tid[k-1];
            end
        end
    end

    assign res_valid = tv[ADD_LAT];
    assign res_id    = tid[ADD_LAT];
    assign res_data  = add_dout;

    // Pipe is empty after this edge when only the last stage (or nothing) is occupied.
    assign drains_out = ~|tv[ADD_LAT-1:0] && !xfer;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (xfer) state_n = BUSY;
            end
            BUSY: begin
                if (drain)           state_n = DRAIN;
                else if (drains_out) state_n = IDLE;
            end
            DRAIN: begin
                if (drains_out)  state_n = IDLE;
                else if (!drain) state_n = BUSY;
            end
            default: state_n = IDLE;
        endcase
    end

    assign idle = (state == IDLE) && ~|tv;

endmodule

// File: tb/tb_math_add_96_arb.sv
// tb/tb_math_add_96_arb.sv - directed self-checking bench for math_add_96_arb with a 3-stage adder model
module tb_math_add_96_arb;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*96-1:0] req_dina;
    logic [NUM_REQ*96-1:0] req_dinb;
    logic [95:0]           add_dina;
    logic [95:0]           add_dinb;
    logic [96:0]           add_dout;
    logic                  res_valid;
    logic [ID_W-1:0]       res_id;
    logic [96:0]           res_data;
    logic                  drain;
    logic                  idle;

    logic [96:0] p0, p1, p2;
    logic [96:0] exp_q [$];
    logic [96:0] exp_v;
    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        p0 <= {1'b0, add_dina} + {1'b0, add_dinb};
        p1 <= p0;
        p2 <= p1;
    end
    assign add_dout = p2;

    math_add_96_arb #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W),
        .ADD_LAT (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_dina  (req_dina),
        .req_dinb  (req_dinb),
        .add_dina  (add_dina),
        .add_dinb  (add_dinb),
        .add_dout  (add_dout),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_data  (res_data),
        .drain     (drain),
        .idle      (idle)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_op(input int i, input logic [95:0] a, input logic [95:0] b);
        req_dina[96*i +: 96] = a;
        req_dinb[96*i +: 96] = b;
    endtask

    initial begin
        req_valid = '0;
        req_dina  = '0;
        req_dinb  = '0;
        drain     = 1'b0;

        // Reset values, including no grant while rst is high
        #12;
        req_valid = '1;
        #1;
        check("rst_ready", 128'(req_ready), 128'h0);
        check("rst_dina", 128'(add_dina), 128'h0);
        check("rst_dinb", 128'(add_dinb), 128'h0);
        check("rst_res_valid", 128'(res_valid), 128'h0);
        check("rst_res_id", 128'(res_id), 128'h0);
        check("rst_idle", 128'(idle), 128'h1);
        req_valid = '0;
        tick();
        rst = 1'b0;
        tick();

        // Single op from requester 1: carry across bit 48
        set_op(1, 96'h1, 96'hFFFF_FFFF_FFFF);
        req_valid = 4'b0010;
        #1;
        check("single_ready", 128'(req_ready), 128'h2);
        tick();
        req_valid = '0;
        check("single_dina", 128'(add_dina), 128'h1);
        check("single_dinb", 128'(add_dinb), 128'hFFFF_FFFF_FFFF);
        check("single_busy", 128'(idle), 128'h0);
        check("single_c1", 128'(res_valid), 128'h0);
        tick();
        check("single_c2", 128'(res_valid), 128'h0);
        tick();
        check("single_c3", 128'(res_valid), 128'h0);
        tick();
        check("single_c4_valid", 128'(res_valid), 128'h1);
        check("single_c4_id", 128'(res_id), 128'h1);
        check("single_c4_data", 128'(res_data), 128'h1_0000_0000_0000);
        tick();
        check("single_c5_valid", 128'(res_valid), 128'h0);
        check("single_c5_idle", 128'(idle), 128'h1);

        // Full carry from requester 3; ptr=2 so 3 wins over 0
        set_op(3, '1, '1);
        set_op(0, 96'h5, 96'h5);
        req_valid = 4'b1001;
        #1;
        check("carry_ready", 128'(req_ready), 128'h8);
        tick();
        req_valid = '0;
        tick();
        tick();
        tick();
        check("carry_valid", 128'(res_valid), 128'h1);
        check("carry_id", 128'(res_id), 128'h3);
        check("carry_data", 128'(res_data), 128'h1_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE);
        tick();

`ifndef MATH_ADD_96_ARB_PRIO_EN
        // Fairness: all four valid for 12 cycles, ptr starts at 0
        for (int k = 0; k < 16; k++) begin
            if (k >= 4) begin
                exp_v = exp_q.pop_front();
                check("fair_res_valid", 128'(res_valid), 128'h1);
                check("fair_res_id", 128'(res_id), 128'((k-4) % 4));
                check("fair_res_data", 128'(res_data), 128'(exp_v));
            end else begin
                check("fair_no_res", 128'(res_valid), 128'h0);
            end
            if (k < 12) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    set_op(i, {64'(k+1), 32'hFFFF_FFFF}, {64'(i), 32'h1});
                end
                exp_q.push_back({1'b0, 64'(k + (k % 4) + 2), 32'h0});
                req_valid = '1;
                #1;
                check("fair_ready", 128'(req_ready), 128'(1 << (k % 4)));
            end else begin
                req_valid = '0;
            end
            tick();
        end
        check("fair_end_valid", 128'(res_valid), 128'h0);
        check("fair_end_idle", 128'(idle), 128'h1);

        // Drain during back-to-back traffic
        for (int k = 0; k < 9; k++) begin
            if (k >= 4 && k < 8) begin
                exp_v = exp_q.pop_front();
                check("drain_res_valid", 128'(res_valid), 128'h1);
                check("drain_res_id", 128'(res_id), 128'(k-4));
                check("drain_res_data", 128'(res_data), 128'(exp_v));
            end else if (k == 8) begin
                check("drain_tail_valid", 128'(res_valid), 128'h0);
                check("drain_idle", 128'(idle), 128'h1);
            end
            if (k == 7) check("drain_not_idle", 128'(idle), 128'h0);
            if (k < 4) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    set_op(i, {64'(k+1), 32'hFFFF_FFFF}, {64'(i), 32'h1});
                end
                exp_q.push_back({1'b0, 64'(2*k + 2), 32'h0});
                req_valid = '1;
                #1;
                check("drain_pre_ready", 128'(req_ready), 128'(1 << k));
            end else begin
                drain     = 1'b1;
                req_valid = '1;
                #1;
                check("drain_ready", 128'(req_ready), 128'h0);
            end
            tick();
        end
        drain     = 1'b0;
        req_valid = '0;
        tick();
`else
        // Strict priority: requester 0 starves requester 2 until it drops
        set_op(0, 96'h10, 96'h20);
        set_op(2, 96'h30, 96'h40);
        for (int k = 0; k < 4; k++) begin
            req_valid = 4'b0101;
            #1;
            check("prio_ready0", 128'(req_ready), 128'h1);
            tick();
        end
        req_valid = 4'b0100;
        #1;
        check("prio_ready2", 128'(req_ready), 128'h4);
        tick();
        req_valid = '0;
        for (int k = 0; k < 6; k++) tick();
        check("prio_idle", 128'(idle), 128'h1);
`endif

        // Reset two cycles after a transfer: op must never be strobed
        set_op(0, 96'h5, 96'h7);
        req_valid = 4'b0001;
        #1;
        check("mid_ready", 128'(req_ready), 128'h1);
        tick();
        req_valid = '0;
        tick();
        rst = 1'b1;
        #1;
        check("mid_rst_dina", 128'(add_dina), 128'h0);
        check("mid_rst_dinb", 128'(add_dinb), 128'h0);
        check("mid_rst_valid", 128'(res_valid), 128'h0);
        check("mid_rst_id", 128'(res_id), 128'h0);
        check("mid_rst_idle", 128'(idle), 128'h1);
        req_valid = 4'b1001;
        #1;
        check("mid_rst_ready", 128'(req_ready), 128'h0);
        req_valid = '0;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            check("mid_no_strobe", 128'(res_valid), 128'h0);
            tick();
        end
        req_valid = 4'b1001;
        #1;
        check("mid_ptr_reset", 128'(req_ready), 128'h1);
        tick();
        req_valid = '0;
        for (int k = 0; k < 6; k++) tick();
        check("final_idle", 128'(idle), 128'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
